// File: rtl/az10_pkg.sv
// AZ10 shared decode constants: opcode classes, sequencer state encoding, word sizing.
// Pure declarations, no latency and no flow control.
package az10_pkg;

    localparam int OPC_W = 4;

    localparam logic [3:0] OPC_EXIT     = 4'hF;
    localparam logic [3:0] OPC_BR_LO    = 4'h3;
    localparam logic [3:0] OPC_BR_HI    = 4'h5;
    localparam logic [3:0] OPC_MULTI_LO = 4'h8;
    localparam logic [3:0] OPC_MULTI_HI = 4'hE;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_ADVANCE = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;
    localparam logic [2:0] ST_ERROR   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_EXEC    = ST_EXEC,
        S_ADVANCE = ST_ADVANCE,
        S_HALT    = ST_HALT,
        S_ERROR   = ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        CLS_SIMPLE,
        CLS_BRANCH,
        CLS_MULTI,
        CLS_EXIT
    } opc_cls_t;

    function automatic int inst_len(input int data_len);
        return OPC_W + data_len;
    endfunction

    function automatic opc_cls_t opc_class(input logic [3:0] opc);
        if (opc == OPC_EXIT)                             return CLS_EXIT;
        else if (opc >= OPC_BR_LO && opc <= OPC_BR_HI)       return CLS_BRANCH;
        else if (opc >= OPC_MULTI_LO && opc <= OPC_MULTI_HI) return CLS_MULTI;
        else                                             return CLS_SIMPLE;
    endfunction

    // ADVANCE dwell tracks the PC unit: pop-branch needs one cycle more than a step.
    function automatic logic [15:0] adv_dwell(input opc_cls_t cls);
        case (cls)
            CLS_BRANCH: return 16'd3;
            CLS_EXIT:   return 16'd1;
            default:    return 16'd2;
        endcase
    endfunction

endpackage

// File: rtl/inst_seq_if.sv
// Sequencer-side bundle: start, fetch port, PC input, datapath handshake and status.
// master = sequencer, slave = memory/PC unit/datapath side.
interface inst_seq_if
    import az10_pkg::*;
#(
    parameter int INST_CAP = 20,
    parameter int DATA_LEN = 8
);
    localparam int PC_W     = $clog2(INST_CAP) + 1;
    localparam int INST_LEN = inst_len(DATA_LEN);

    logic                start;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_rd;
    logic [INST_LEN-1:0] imem_data;
    logic [3:0]          control_bus;
    logic [DATA_LEN-1:0] operand;
    logic                unit_en;
    logic                unit_done;
    logic                pc_en;
    logic                busy;
    logic                halted;
    logic                err;
    logic [15:0]         inst_count;

    modport master (
        input  start, pc, imem_data, unit_done,
        output imem_addr, imem_rd, control_bus, operand, unit_en, pc_en,
               busy, halted, err, inst_count
    );

    modport slave (
        output start, pc, imem_data, unit_done,
        input  imem_addr, imem_rd, control_bus, operand, unit_en, pc_en,
               busy, halted, err, inst_count
    );

endinterface

// File: rtl/inst_seq_wait_timer.sv
// Cycle timer shared by the EXEC watchdog and the ADVANCE dwell; expired is combinational.
// count holds completed cycles, so expired flags the limit-th cycle since the last clr.
module wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         run,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (run && count != {W{1'b1}})
            count <= count + {{(W-1){1'b0}}, 1'b1};
    end

    assign expired = ({1'b0, count} + {{W{1'b0}}, 1'b1}) == {1'b0, limit};

endmodule

// File: rtl/inst_seq.sv
// AZ10 instruction sequencer: fetch, decode, execute handshake, PC advance, retire count.
// FETCH-to-FETCH 5 cycles (simple/branch) or 4+k (multi); datapath stalls EXEC via unit_done.
module inst_seq
    import az10_pkg::*;
#(
    parameter int INST_CAP = 20,
    parameter int DATA_LEN = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    inst_seq_if.master   bus
);
    localparam int PC_W     = $clog2(INST_CAP) + 1;
    localparam int INST_LEN = inst_len(DATA_LEN);

    state_t              state;
    opc_cls_t            cls_q;
    opc_cls_t            dec_cls;
    logic [PC_W-1:0]     imem_addr_q;
    logic                imem_rd_q;
    logic [3:0]          ctrl_q;
    logic [DATA_LEN-1:0] operand_q;
    logic                unit_en_q;
    logic                pc_en_q;
    logic                busy_q;
    logic                halted_q;
    logic                err_q;
    logic [15:0]         inst_count_q;

    logic                tmr_clr;
    logic                tmr_run;
    logic                tmr_exp;
    logic                exec_leave;
    logic [15:0]         tmr_limit;

    assign dec_cls = opc_class(bus.imem_data[INST_LEN-1:DATA_LEN]);

    // Done is checked ahead of the watchdog, so a late unit_done still wins.
    always_comb begin
        tmr_run    = (state == S_EXEC) || (state == S_ADVANCE);
        tmr_limit  = (state == S_EXEC) ? 16'(MAX_WAIT) : adv_dwell(cls_q);
        exec_leave = (state == S_EXEC) && (cls_q == CLS_SIMPLE || bus.unit_done);
        tmr_clr    = !tmr_run || exec_leave || tmr_exp;
    end

    wait_timer #(.W(16)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .limit   (tmr_limit),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cls_q        <= CLS_SIMPLE;
            imem_addr_q  <= '0;
            imem_rd_q    <= 1'b0;
            ctrl_q       <= 4'h0;
            operand_q    <= '0;
            unit_en_q    <= 1'b0;
            pc_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            inst_count_q <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_FETCH;
                        imem_rd_q   <= 1'b1;
                        imem_addr_q <= bus.pc;
                        busy_q      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    imem_rd_q <= 1'b0;
                    state     <= S_DECODE;
                end
                S_DECODE: begin
                    ctrl_q    <= bus.imem_data[INST_LEN-1:DATA_LEN];
                    operand_q <= bus.imem_data[DATA_LEN-1:0];
                    cls_q     <= dec_cls;
                    if (dec_cls == CLS_BRANCH || dec_cls == CLS_EXIT) begin
                        state   <= S_ADVANCE;
                        pc_en_q <= 1'b1;
                    end else begin
                        state     <= S_EXEC;
                        unit_en_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_leave) begin
                        unit_en_q <= 1'b0;
                        pc_en_q   <= 1'b1;
                        state     <= S_ADVANCE;
                    end else if (tmr_exp) begin
                        unit_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= S_ERROR;
                    end
                end
                S_ADVANCE: begin
                    pc_en_q <= 1'b0;
                    if (tmr_exp) begin
                        if (inst_count_q != 16'hFFFF)
                            inst_count_q <= inst_count_q + 16'd1;
                        if (cls_q == CLS_EXIT) begin
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            imem_rd_q   <= 1'b1;
                            imem_addr_q <= bus.pc;
                            state       <= S_FETCH;
                        end
                    end
                end
                default: ;  // HALT and ERROR are sticky until reset
            endcase
        end
    end

    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_rd     = imem_rd_q;
    assign bus.control_bus = ctrl_q;
    assign bus.operand     = operand_q;
    assign bus.unit_en     = unit_en_q;
    assign bus.pc_en       = pc_en_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;
    assign bus.inst_count  = inst_count_q;

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: memory/PC-unit/datapath models, scoreboard of fetch/retire/stop events.
module tb_inst_seq;
    import az10_pkg::*;

    localparam int INST_CAP = 20;
    localparam int DATA_LEN = 8;
    localparam int MAX_WAIT = 10;
    localparam int PC_W     = $clog2(INST_CAP) + 1;
    localparam int IL       = inst_len(DATA_LEN);

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    inst_seq_if #(.INST_CAP(INST_CAP), .DATA_LEN(DATA_LEN)) bus ();

    inst_seq #(.INST_CAP(INST_CAP), .DATA_LEN(DATA_LEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_FETCH, EV_PCEN, EV_HALT, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] v3;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // ---------------- environment models ----------------
    logic [IL-1:0]   mem [INST_CAP];
    logic [PC_W-1:0] pc_m;
    logic [PC_W-1:0] pc_set;
    logic            pc_set_req;
    int              exec_cnt;

    always @(posedge clk) begin
        if (bus.imem_rd)
            bus.imem_data <= (int'(bus.imem_addr) < INST_CAP) ? mem[bus.imem_addr] : '0;
    end

    always @(posedge clk) begin
        if (pc_set_req)
            pc_m <= pc_set;
        else if (bus.pc_en) begin
            if (opc_class(bus.control_bus) == CLS_BRANCH)
                pc_m <= bus.operand[PC_W-1:0];
            else
                pc_m <= pc_m + 1'b1;
        end
    end
    assign bus.pc = pc_m;

    always @(posedge clk) exec_cnt <= bus.unit_en ? exec_cnt + 1 : 0;

    // EXEC cycle on which the datapath reports completion; 0 = never.
    function automatic int done_cyc(input logic [3:0] op);
        case (op)
            4'h8:    return 1;
            4'h9:    return 4;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        bus.unit_done = 1'b0;
        if (bus.unit_en && done_cyc(bus.control_bus) != 0)
            bus.unit_done = (exec_cnt == done_cyc(bus.control_bus) - 1);
    end

    // ---------------- monitor ----------------
    int   cyc = 0, last_fetch = 0, ex_cycles = 0;
    bit   have_prev = 0, halted_p = 0, err_p = 0;

    function automatic void emit(input ev_kind_t k, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind=%0d v1=%0h v2=%0h v3=%0h, required none", k, a, b, c);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("ev_kind@%0d", cyc), 32'(k), 32'(e.kind));
        chk($sformatf("ev%0d_v1@%0d", k, cyc), 32'(a), 32'(e.v1));
        chk($sformatf("ev%0d_v2@%0d", k, cyc), 32'(b), 32'(e.v2));
        chk($sformatf("ev%0d_v3@%0d", k, cyc), 32'(c), 32'(e.v3));
    endfunction

    always @(negedge clk) begin
        logic [15:0] flags;
        cyc++;
        flags = {12'h0, bus.busy, bus.unit_en, bus.pc_en, bus.imem_rd};
        if (!rstn) begin
            have_prev = 0;
            ex_cycles = 0;
            halted_p  = 0;
            err_p     = 0;
        end else begin
            if (bus.unit_en) ex_cycles++;
            if (bus.imem_rd) begin
                emit(EV_FETCH, 16'(bus.imem_addr), have_prev ? 16'(cyc - last_fetch) : 16'h0,
                     bus.inst_count);
                last_fetch = cyc;
                have_prev  = 1;
                ex_cycles  = 0;
            end
            if (bus.pc_en)
                emit(EV_PCEN, 16'(bus.control_bus), 16'(ex_cycles), 16'(bus.operand));
            if (bus.halted && !halted_p)
                emit(EV_HALT, bus.inst_count, flags, 16'(bus.control_bus));
            if (bus.err && !err_p)
                emit(EV_ERR, 16'(ex_cycles), flags, 16'(bus.control_bus));
            halted_p = bus.halted;
            err_p    = bus.err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic exp_ev(input ev_kind_t k, input int a, input int b, input int c);
        exp_q.push_back('{kind: k, v1: 16'(a), v2: 16'(b), v3: 16'(c)});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_addr"},   32'(bus.imem_addr), 0);
        chk({tag, "_control_bus"}, 32'(bus.control_bus), 0);
        chk({tag, "_operand"},     32'(bus.operand), 0);
        chk({tag, "_inst_count"},  32'(bus.inst_count), 0);
        chk({tag, "_imem_rd"},     32'(bus.imem_rd), 0);
        chk({tag, "_unit_en"},     32'(bus.unit_en), 0);
        chk({tag, "_pc_en"},       32'(bus.pc_en), 0);
        chk({tag, "_busy"},        32'(bus.busy), 0);
        chk({tag, "_halted"},      32'(bus.halted), 0);
        chk({tag, "_err"},         32'(bus.err), 0);
    endtask

    task automatic reset_with_pc(input int p);
        @(negedge clk);
        rstn       = 1'b0;
        pc_set     = PC_W'(p);
        pc_set_req = 1'b1;
        @(negedge clk);
        pc_set_req = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_stop(input string tag, input int budget);
        int n = 0;
        while (!(bus.halted || bus.err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_stop_timeout"}, 32'(bus.halted | bus.err), 1);
    endtask

    initial begin
        int n;
        bus.start  = 1'b0;
        pc_set     = '0;
        pc_set_req = 1'b0;
        for (int i = 0; i < INST_CAP; i++) mem[i] = '0;

        // Program 1: simple, multi(4), branch to 5, multi(1), simple, exit
        mem[0] = {4'h1, 8'h11};
        mem[1] = {4'h9, 8'h22};
        mem[2] = {4'h4, 8'h05};
        mem[5] = {4'h8, 8'h33};
        mem[6] = {4'h2, 8'h66};
        mem[7] = {4'hF, 8'h77};
        reset_with_pc(0);
        #1 chk_reset("rst1");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_ev(EV_FETCH, 0, 0, 0);  exp_ev(EV_PCEN, 4'h1, 1, 8'h11);
        exp_ev(EV_FETCH, 1, 5, 1);  exp_ev(EV_PCEN, 4'h9, 4, 8'h22);
        exp_ev(EV_FETCH, 2, 8, 2);  exp_ev(EV_PCEN, 4'h4, 0, 8'h05);
        exp_ev(EV_FETCH, 5, 5, 3);  exp_ev(EV_PCEN, 4'h8, 1, 8'h33);
        exp_ev(EV_FETCH, 6, 5, 4);  exp_ev(EV_PCEN, 4'h2, 1, 8'h66);
        exp_ev(EV_FETCH, 7, 5, 5);  exp_ev(EV_PCEN, 4'hF, 0, 8'h77);
        exp_ev(EV_HALT, 6, 0, 4'hF);
        pulse_start();
        wait_stop("prog1", 200);
        bus.start = 1'b1;
        repeat (8) @(negedge clk);
        bus.start = 1'b0;
        chk("halt_sticky",      32'(bus.halted), 1);
        chk("halt_busy",        32'(bus.busy), 0);
        chk("halt_control_bus", 32'(bus.control_bus), 32'h0F);
        chk("halt_inst_count",  32'(bus.inst_count), 6);

        // Program 2: multi op that never completes trips the watchdog
        mem[10] = {4'hC, 8'h44};
        reset_with_pc(10);
        #1 chk_reset("rst2");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_ev(EV_FETCH, 10, 0, 0);
        exp_ev(EV_ERR, MAX_WAIT, 0, 4'hC);
        pulse_start();
        wait_stop("prog2", 200);
        bus.start = 1'b1;
        repeat (6) @(negedge clk);
        bus.start = 1'b0;
        chk("err_sticky",   32'(bus.err), 1);
        chk("err_unit_en",  32'(bus.unit_en), 0);
        chk("err_busy",     32'(bus.busy), 0);
        chk("err_operand",  32'(bus.operand), 32'h44);
        chk("err_inst_cnt", 32'(bus.inst_count), 0);

        // Program 3: reset during the third instruction's ADVANCE, then restart
        for (int i = 0; i < INST_CAP; i++) mem[i] = '0;
        mem[0] = {4'h1, 8'hA0};
        mem[1] = {4'h6, 8'hA1};
        mem[2] = {4'h7, 8'hA2};
        mem[3] = {4'hF, 8'hA3};
        reset_with_pc(0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_ev(EV_FETCH, 0, 0, 0);  exp_ev(EV_PCEN, 4'h1, 1, 8'hA0);
        exp_ev(EV_FETCH, 1, 5, 1);  exp_ev(EV_PCEN, 4'h6, 1, 8'hA1);
        exp_ev(EV_FETCH, 2, 5, 2);  exp_ev(EV_PCEN, 4'h7, 1, 8'hA2);
        pulse_start();
        n = 0;
        for (int t = 0; t < 100 && n < 3; t++) begin
            if (bus.pc_en) n++;
            if (n < 3) @(negedge clk);
        end
        chk("third_pc_en_seen", 32'(n), 3);
        #2 rstn = 1'b0;
        #1 chk_reset("mid_adv");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_ev(EV_FETCH, 2, 0, 0);  exp_ev(EV_PCEN, 4'h7, 1, 8'hA2);
        exp_ev(EV_FETCH, 3, 5, 1);  exp_ev(EV_PCEN, 4'hF, 0, 8'hA3);
        exp_ev(EV_HALT, 2, 0, 4'hF);
        pulse_start();
        wait_stop("prog3", 200);
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_seq.md
# inst_seq

Instruction sequencer for the AZ10 core. It fetches each instruction word from instruction memory at the current PC and decodes its 4-bit opcode onto `control_bus`. It then enables the datapath unit and waits for completion, and finally steps the PC unit through its advance/branch cycles. It sits between instruction memory, the PC unit and the ALU/memory datapath, and owns the retire count, halt and watchdog-error status.

## Interface
- `INST_CAP`, 20: instruction memory depth; PC width is `$clog2(INST_CAP)+1`.
- `DATA_LEN`, 8: operand/data width.
- `INST_LEN`, `4+DATA_LEN`: instruction word; opcode in `[INST_LEN-1:DATA_LEN]`, operand in `[DATA_LEN-1:0]`.
- `MAX_WAIT`, 255: maximum EXEC cycles before the watchdog trips (1..65535).

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution; sampled only in IDLE.
- `pc`  in  `$clog2(INST_CAP)+1`  current PC from the PC unit.
- `imem_addr`  out  `$clog2(INST_CAP)+1`  fetch address.
- `imem_rd`  out  1  fetch strobe; data valid on `imem_data` one cycle later.
- `imem_data`  in  `INST_LEN`  fetched word.
- `control_bus`  out  4  latched opcode to the PC unit and datapath.
- `operand`  out  `DATA_LEN`  latched operand.
- `unit_en`  out  1  datapath execute enable.
- `unit_done`  in  1  datapath completion for multi-cycle ops.
- `pc_en`  out  1  one-cycle pulse that starts a PC-unit step.
- `busy`  out  1  high in every state except IDLE, HALT and ERROR.
- `halted`  out  1  exit opcode retired.
- `err`  out  1  watchdog tripped.
- `inst_count`  out  16  retired instructions, saturating at 16'hFFFF.

## Operation
- Opcode classes:
  - simple: 0, 1, 2, 6, 7.
  - branch: 3, 4, 5.
  - multi: 8–14.
  - exit: 15.
- States: IDLE, FETCH, DECODE, EXEC, ADVANCE, HALT, ERROR.
- IDLE: `start`=1 → FETCH. Otherwise stay.
- FETCH: `imem_addr`=`pc`, `imem_rd`=1 for one cycle → DECODE.
- DECODE: latch `imem_data` into the instruction register; `control_bus`/`operand` update at this edge.
  - branch → ADVANCE.
  - exit → ADVANCE.
  - otherwise → EXEC.
- EXEC:
  - `unit_en`=1 while in EXEC.
  - simple: single cycle, `unit_done` ignored → ADVANCE.
  - multi: stay until `unit_done` is sampled high → ADVANCE. If `MAX_WAIT` cycles elapse without `unit_done` → ERROR.
- ADVANCE:
  - `pc_en`=1 in the first cycle only.
  - Dwell is 2 cycles for simple/multi and 3 cycles for branch, matching the PC unit's step/pop-branch latency.
  - At dwell end, `inst_count` increments (saturating) → FETCH.
  - exit: dwell 1 cycle → HALT, count increments.
- HALT: `halted`=1, all enables 0, sticky until reset. `start` is ignored.
- ERROR: `err`=1, all enables 0, sticky until reset.
- `control_bus`/`operand` hold their last latched value through HALT/ERROR.

## Timing
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - `imem_addr`, `control_bus`, `operand`, `inst_count` = 0;
  - `imem_rd`, `unit_en`, `pc_en`, `busy`, `halted`, `err` = 0.
- Reset mid-EXEC or mid-ADVANCE aborts with no retire.
- Outputs are registered and change only on `clk` rising edges (except under reset).
- Latency from FETCH entry to next FETCH entry:
  - simple: 5 cycles;
  - branch: 5 cycles;
  - multi: 4+k cycles, where k is the EXEC cycle count (k=1 if `unit_done` is high in the first EXEC cycle).
- `unit_done` sampled in the same cycle the watchdog reaches `MAX_WAIT`: done wins → ADVANCE.
- `start` held high after halt or error has no effect.
- `start` asserted in a non-IDLE state is ignored.
- A `pc` change outside ADVANCE does not matter: `pc` is sampled only in FETCH.

## Structure
- Shared package `az10_pkg` holds:
  - opcode class constants (`OPC_EXIT`=4'hF, branch and multi range bounds);
  - state encoding localparams;
  - the `INST_LEN` derivation.
  The PC unit and datapath decoders reuse them.
- Sub-module `wait_timer` (16-bit):
  - `clr` clears the count; `run` increments it;
  - `expired` asserts when the count reaches `MAX_WAIT`.
  - Shared by the EXEC watchdog (`MAX_WAIT`) and the ADVANCE dwell (2/3/1).

## Test plan
- Reset, then `start` with `imem[0]`=opcode 1 → `unit_en` one cycle, `pc_en` pulse, `inst_count`=1, next FETCH 5 cycles after the first.
- Opcode 9 with `unit_done` asserted on the 4th EXEC cycle → EXEC lasts 4 cycles, FETCH-to-FETCH 8 cycles, `control_bus`=4'h9 throughout.
- Opcode 4 (branch), operand 8'h05 → no `unit_en`, 3-cycle ADVANCE, `imem_addr` at next FETCH equals the new `pc`.
- Opcode 12 with `unit_done` never asserted, `MAX_WAIT`=10 → `err`=1 after 10 EXEC cycles, enables 0, `start` ignored.
- Opcode 15 → `pc_en` pulse with `control_bus`=4'hF, then `halted`=1, `busy`=0, `inst_count` incremented.
- `rstn` low during ADVANCE of the 3rd instruction → all outputs 0 immediately, `inst_count`=0; a restart re-fetches at the current `pc`.
